// File: rtl/serial_bit_feeder_if.sv
// Word-load handshake and serial output bundle for serial_bit_feeder.
// The producer side is the master; the feeder is the slave.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, sout, sout_valid, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, sout, sout_valid, busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: a one-word holding register in front of a shift
// register lets consecutive words stream out one bit per clock without gaps.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  serial_bit_feeder_if.slave  bus
);
  localparam int unsigned     CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic             head;

  assign bus.load_ready = !hold_full_q && !reset;
  assign accept         = bus.load_valid && bus.load_ready;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], 1'b0};
      head    = shreg_q[WIDTH-1];
    end else begin
      shifted = {1'b0, shreg_q[WIDTH-1:1]};
      head    = shreg_q[0];
    end
  end

  // Accept needs hold empty and transfer needs hold full, so the two
  // updates to hold_full_d below never collide in one cycle.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;

    if (accept) begin
      hold_d      = bus.load_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shreg_d     = hold_q;
          cnt_d       = CNT_FULL;
          hold_full_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          if (hold_full_q) begin
            shreg_d     = hold_q;
            cnt_d       = CNT_FULL;
            hold_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout       = (state_q == SHIFT) && head;
  assign bus.busy       = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share one
// stimulus stream and are checked every cycle against a word-schedule model.
module tb_serial_bit_feeder;
  localparam int unsigned W = 8;

  logic clk;
  logic reset;

  serial_bit_feeder_if #(.WIDTH(W)) m_if ();
  serial_bit_feeder_if #(.WIDTH(W)) l_if ();

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (l_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word is scheduled to start at the later of the edge
  // after its accept and the edge right after the previous word's last bit.
  typedef struct {
    longint      acc;
    longint      start;
    logic [W-1:0] data;
  } wrd_t;

  wrd_t   sched[$];
  longint edge_n = 0;
  bit     model_on = 1'b0;

  function automatic bit model_hold(input longint ee);
    foreach (sched[i]) if (sched[i].acc <= ee && ee < sched[i].start) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_bit(input longint ee, input bit msb, output bit valid);
    valid = 1'b0;
    foreach (sched[i]) begin
      if (sched[i].start <= ee && ee < sched[i].start + W) begin
        int unsigned idx;
        valid = 1'b1;
        idx = int'(ee - sched[i].start);
        return msb ? sched[i].data[W-1-idx] : sched[i].data[idx];
      end
    end
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        sched.delete();
        model_on = 1'b1;
      end else if (model_on) begin
        if (m_if.load_valid && !model_hold(edge_n - 1)) begin
          wrd_t w;
          longint st;
          st = edge_n + 1;
          if (sched.size() > 0 && sched[$].start + W > st) st = sched[$].start + W;
          w.acc = edge_n;
          w.start = st;
          w.data = m_if.load_data;
          sched.push_back(w);
        end
        while (sched.size() > 1 && sched[0].start + W <= edge_n) void'(sched.pop_front());
      end
    end
  end

  // Per-cycle comparison plus a log of emitted bits for literal checks.
  logic [31:0] log_m, log_l;
  int          log_n, run_len, max_run, acc_cnt;

  initial begin
    bit ev, eb_m, eb_l, vdummy, eh;
    forever begin
      @(posedge clk);
      #1;
      if (model_on) begin
        eh   = model_hold(edge_n);
        eb_m = model_bit(edge_n, 1'b1, ev);
        eb_l = model_bit(edge_n, 1'b0, vdummy);
        check("msb_load_ready", 32'(m_if.load_ready), 32'(!reset && !eh));
        check("msb_sout_valid", 32'(m_if.sout_valid), 32'(ev));
        check("msb_sout",       32'(m_if.sout),       32'(eb_m));
        check("msb_busy",       32'(m_if.busy),       32'(ev || eh));
        check("lsb_load_ready", 32'(l_if.load_ready), 32'(!reset && !eh));
        check("lsb_sout_valid", 32'(l_if.sout_valid), 32'(ev));
        check("lsb_sout",       32'(l_if.sout),       32'(eb_l));
        check("lsb_busy",       32'(l_if.busy),       32'(ev || eh));
      end
      if (m_if.sout_valid) begin
        log_m = {log_m[30:0], m_if.sout};
        log_l = {log_l[30:0], l_if.sout};
        log_n++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  // Handshake sampled just before each rising edge, when inputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (m_if.load_valid && m_if.load_ready) acc_cnt++;
    end
  end

  task automatic clear_log();
    log_m = '0; log_l = '0; log_n = 0; run_len = 0; max_run = 0; acc_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    m_if.load_valid = v; m_if.load_data = d;
    l_if.load_valid = v; l_if.load_data = d;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int unsigned waits;
    waits = 0;
    @(negedge clk);
    drive(1'b1, d);
    while (!m_if.load_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (waits >= 200) begin
      failures++;
      $display("FAIL accept_timeout: load_ready stayed 0 for %0d cycles, required 1", waits);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    drive(1'b0, '0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 8'hAA);
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    check("rst_load_ready", 32'(m_if.load_ready), 32'd0);
    check("rst_sout_valid", 32'(m_if.sout_valid), 32'd0);
    check("rst_busy",       32'(m_if.busy),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0);
    #1;
    check("rel_load_ready", 32'(m_if.load_ready), 32'd1);

    clear_log();
    send_word(8'h66);
    idle(12);
    check("single_bits",  log_m, 32'h66);
    check("single_count", 32'(log_n), 32'd8);
    check("single_lsb",   log_l, 32'h66);

    clear_log();
    send_word(8'h66);
    send_word(8'hD9);
    idle(20);
    check("b2b_bits", log_m, 32'h66D9);
    check("b2b_run",  32'(max_run), 32'd16);

    clear_log();
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF0);
    idle(30);
    check("bp_bits",    log_m, 32'hA53CF0);
    check("bp_count",   32'(log_n), 32'd24);
    check("bp_accepts", 32'(acc_cnt), 32'd3);
    check("bp_run",     32'(max_run), 32'd24);

    clear_log();
    send_word(8'h06);
    idle(12);
    check("lsb_bits", log_l, 32'h60);
    check("msb_06",   log_m, 32'h06);

    clear_log();
    send_word(8'hFF);
    send_word(8'h81);
    @(negedge clk);
    drive(1'b0, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(m_if.sout_valid), 32'd0);
    check("rst_mid_busy",  32'(m_if.busy),       32'd0);
    repeat (20) @(negedge clk);
    check("rst_mid_bits",  log_m, 32'h7);
    check("rst_mid_count", 32'(log_n), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Upstream feeder for the 1-bit serial sequence detectors. It accepts parallel words through a valid/ready handshake and shifts them out one bit per clock on `sout`, which drives the detector's `din`. A one-word holding register lets consecutive words stream with no idle bits between them, so a pattern can span a word boundary.

## Interface
- `WIDTH`, default 8: bits per word; legal values are 2 or more.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `load_valid`  in  1  producer has a word on `load_data`.
- `load_data`  in  WIDTH  word to serialize; sampled only on an accepting edge.
- `load_ready`  out  1  feeder can take a word this cycle.
- `sout`  out  1  serial bit; connects to the detector's `din`.
- `sout_valid`  out  1  `sout` carries a data bit this cycle.
- `busy`  out  1  shifter active or holding register full.

## Operation
- Storage:
  - holding register `hold` plus flag `hold_full`;
  - shift register `shreg`;
  - bit counter `cnt` of width clog2(WIDTH)+1;
  - state bit `state`: IDLE or SHIFT.
- Handshake:
  - `load_ready` = !hold_full && !reset.
  - Accept when `load_valid` && `load_ready` at a rising edge; `load_data` then goes into `hold` and `hold_full` sets.
  - `load_valid` with `load_ready` low has no effect; the producer holds the word.
  - `load_data` is ignored whenever `load_valid` is low.
- IDLE:
  - `sout` = 0, `sout_valid` = 0.
  - If `hold_full`: next edge moves `hold` into `shreg`, sets `cnt` = WIDTH, clears `hold_full`, and enters SHIFT.
- SHIFT:
  - `sout` = current head bit of `shreg` (MSB or LSB per `MSB_FIRST`); `sout_valid` = 1.
  - Each edge shifts `shreg` by one toward the head and decrements `cnt`.
  - When `cnt` == 1 (last bit on `sout`):
    - if `hold_full`, the same edge reloads `shreg` from `hold`, sets `cnt` = WIDTH, clears `hold_full`, and stays in SHIFT (gapless);
    - otherwise the edge goes to IDLE.
- Simultaneous accept and transfer at one edge cannot occur: accept requires `hold_full` = 0, and transfer requires `hold_full` = 1.
- `busy` = (state == SHIFT) || hold_full.
- `sout` is 0 whenever `sout_valid` is 0. Downstream sees explicit zeros during gaps.

## Timing
- Reset values (outputs and state after a reset edge):
  - `sout` = 0, `sout_valid` = 0, `busy` = 0;
  - `hold_full` = 0, `state` = IDLE, `cnt` = 0, `shreg` = 0;
  - `load_ready` is 0 while `reset` is high and 1 in the first cycle after it falls.
- Latency: a word accepted at edge k shows its first bit on `sout` after edge k+1. Bit i (i = 0..WIDTH-1, in shift order) is valid after edge k+1+i.
- Holding-register refill: `hold` empties at edge k+1, so `load_ready` is high again after edge k+1. The producer can accept the next word at any edge from k+2 to k+WIDTH and still get a gapless stream.
- Sustained throughput: one bit per clock with no bubbles, provided each next word is accepted no later than the edge showing the last bit of the current word.
- Reset mid-operation: the in-flight word and any held word are discarded. Outputs reach their reset values after the reset edge; no partial word resumes.
- Outputs are registered or decoded from registers. There is no combinational path from `load_valid` or `load_data` to any output.

## Test plan
- Reset check: assert `reset` for 2 cycles, with `load_valid` = 1 throughout. Required: `load_ready` = 0, `sout` = 0, `sout_valid` = 0, `busy` = 0 during reset; `load_ready` = 1 in the first cycle after release.
- Single word, MSB_FIRST = 1, WIDTH = 8, word 8'h66 accepted at edge k. Required: `sout` = 0,1,1,0,0,1,1,0 after edges k+1..k+8, with `sout_valid` = 1 on exactly those 8 cycles, then IDLE with `sout` = 0.
- Back-to-back words 8'h66 then 8'hD9. Required: 16 consecutive valid bits 0110011011011001 with no gap, and `load_ready` low only during the cycles when `hold_full` is set.
- Backpressure: present 3 words, each with `load_valid` held continuously. Required: exactly 3 accepts, each word shifted exactly once and in order, and no word lost or duplicated while `load_ready` = 0.
- LSB_FIRST (`MSB_FIRST` = 0), word 8'h06. Required: `sout` sequence 0,1,1,0,0,0,0,0.
- Reset mid-word: assert `reset` after the 3rd bit of 8'hFF with a second word held. Required: `sout_valid` = 0 from the next cycle, and no further bits appear from either word.
